dma_loader: RTL and testbench

DMA_LOADER -- requirements
Module: dma_loader

---
 rtl/dma_loader.sv | 121 ++++++++++++
 tb/tb_dma_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_loader.sv
// UART boot loader: takes a little-endian word count, streams program words
// to the hub, answers ACK/NAK, then forwards input-data words forever.
module dma_loader #(
  parameter int unsigned MAX_INSTR_WORDS = 256,
  parameter logic [7:0]  ACK_BYTE        = 8'hAA,
  parameter logic [7:0]  NAK_BYTE        = 8'hEE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  sdata,
  output logic [31:0] data,
  output logic        instr_ready,
  output logic        mem_ready,
  output logic        program_loaded
);

  typedef enum logic [2:0] {
    WAIT_LEN,
    LOAD,
    ACK,
    NAK,
    RUN
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [1:0]  bcnt;
  logic [31:0] asm_q;
  logic [31:0] wcnt;
  logic [31:0] len_q;
  logic [31:0] word;
  logic        take;
  logic        word_done;

  // Bytes are only accepted in the assembling states.
  assign take = rx_ready &&
    (state == WAIT_LEN || state == LOAD || state == RUN);
  assign word      = {rx_data, asm_q[31:8]};
  assign word_done = take && (bcnt == 2'd3);

  assign program_loaded = (state == RUN);

  always_comb begin
    state_d  = state;
    tx_start = 1'b0;
    sdata    = 8'h00;
    unique case (state)
      WAIT_LEN: begin
        if (word_done) begin
          if (word == 32'd0)
            state_d = ACK;
          else if (word > 32'(MAX_INSTR_WORDS))
            state_d = NAK;
          else
            state_d = LOAD;
        end
      end
      LOAD: begin
        if (word_done && (wcnt + 32'd1 == len_q))
          state_d = ACK;
      end
      ACK: begin
        sdata = ACK_BYTE;
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = RUN;
        end
      end
      NAK: begin
        sdata = NAK_BYTE;
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = WAIT_LEN;
        end
      end
      RUN: state_d = RUN;
      default: state_d = WAIT_LEN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= WAIT_LEN;
      bcnt        <= 2'd0;
      asm_q       <= 32'd0;
      wcnt        <= 32'd0;
      len_q       <= 32'd0;
      data        <= 32'd0;
      instr_ready <= 1'b0;
      mem_ready   <= 1'b0;
    end else begin
      state       <= state_d;
      instr_ready <= 1'b0;
      mem_ready   <= 1'b0;
      if (state == ACK || state == NAK)
        bcnt <= 2'd0;
      else if (take) begin
        asm_q <= word;
        bcnt  <= bcnt + 2'd1;
      end
      if (word_done) begin
        if (state == WAIT_LEN) begin
          len_q <= word;
          wcnt  <= 32'd0;
        end else if (state == LOAD) begin
          data        <= word;
          instr_ready <= 1'b1;
          wcnt        <= wcnt + 32'd1;
        end else begin
          data      <= word;
          mem_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_loader.sv
// Randomised + directed bench for dma_loader against a byte-queue
// reference model of the loader protocol.
module tb_dma_loader;

  localparam int unsigned MAX  = 256;
  localparam logic [7:0]  ACKB = 8'hAA;
  localparam logic [7:0]  NAKB = 8'hEE;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  sdata;
  logic [31:0] data;
  logic        instr_ready;
  logic        mem_ready;
  logic        program_loaded;

  always #5 clock = ~clock;

  dma_loader #(
    .MAX_INSTR_WORDS(MAX),
    .ACK_BYTE(ACKB),
    .NAK_BYTE(NAKB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .tx_busy(tx_busy),
    .tx_start(tx_start),
    .sdata(sdata),
    .data(data),
    .instr_ready(instr_ready),
    .mem_ready(mem_ready),
    .program_loaded(program_loaded)
  );

  int vectors = 0;
  int miscompares = 0;
  int fail_prints = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("FAIL %s: got %08h expected %08h at %0t",
                 name, act, exp, $time);
      end
    end
  endtask

  // Reference model: protocol phase plus a queue of pending bytes.
  localparam int M_LEN  = 0;
  localparam int M_LOAD = 1;
  localparam int M_ACK  = 2;
  localparam int M_NAK  = 3;
  localparam int M_RUN  = 4;

  int          m_mode = M_LEN;
  logic [7:0]  q[$];
  logic [31:0] m_data = 32'd0;
  logic [31:0] m_left = 32'd0;
  logic [31:0] w;
  bit          m_instr = 1'b0;
  bit          m_mem = 1'b0;
  bit          m_started = 1'b0;
  bit          m_rst = 1'b0;

  always @(posedge clock) begin
    m_started = 1'b1;
    m_rst     = reset;
    m_instr   = 1'b0;
    m_mem     = 1'b0;
    if (reset) begin
      m_mode = M_LEN;
      q.delete();
      m_data = 32'd0;
    end else if (m_mode == M_ACK) begin
      if (!tx_busy) m_mode = M_RUN;
    end else if (m_mode == M_NAK) begin
      if (!tx_busy) m_mode = M_LEN;
    end else if (rx_ready) begin
      q.push_back(rx_data);
      if (q.size() == 4) begin
        w = 32'(q[0]) + (32'(q[1]) << 8) +
            (32'(q[2]) << 16) + (32'(q[3]) << 24);
        q.delete();
        if (m_mode == M_LEN) begin
          if (w == 32'd0) m_mode = M_ACK;
          else if (w > MAX) m_mode = M_NAK;
          else begin
            m_left = w;
            m_mode = M_LOAD;
          end
        end else if (m_mode == M_LOAD) begin
          m_data  = w;
          m_instr = 1'b1;
          m_left  = m_left - 32'd1;
          if (m_left == 32'd0) m_mode = M_ACK;
        end else begin
          m_data = w;
          m_mem  = 1'b1;
        end
      end
    end
  end

  logic [31:0] instr_log[$];
  logic [31:0] mem_log[$];
  logic [7:0]  tx_log[$];
  bit          exp_tx;

  always @(negedge clock) begin
    if (m_started) begin
      exp_tx = (m_mode == M_ACK || m_mode == M_NAK) && !tx_busy;
      chk("instr_ready", 32'(instr_ready), 32'(m_instr));
      chk("mem_ready", 32'(mem_ready), 32'(m_mem));
      chk("data", data, m_data);
      chk("tx_start", 32'(tx_start), 32'(exp_tx));
      if (exp_tx)
        chk("sdata", 32'(sdata), 32'(m_mode == M_ACK ? ACKB : NAKB));
      if (m_rst)
        chk("sdata_reset", 32'(sdata), 32'd0);
      chk("program_loaded", 32'(program_loaded), 32'(m_mode == M_RUN));
      chk("strobe_excl", 32'(instr_ready && mem_ready), 32'd0);
      if (instr_ready === 1'b1) instr_log.push_back(data);
      if (mem_ready === 1'b1) mem_log.push_back(data);
      if (tx_start === 1'b1) tx_log.push_back(sdata);
    end
  end

  bit rand_busy = 1'b0;

  task automatic drive(input bit v, input logic [7:0] b);
    @(posedge clock);
    #2;
    rx_ready = v;
    rx_data  = v ? b : 8'($urandom);
    if (rand_busy) tx_busy = ($urandom_range(0, 3) == 0);
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b1, b);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00);
  endtask

  task automatic send_word(input logic [31:0] v, input int gap);
    for (int i = 0; i < 4; i++) begin
      send(v[8*i +: 8]);
      if (gap > 0) idle($urandom_range(0, gap));
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2;
    reset    = 1'b1;
    rx_ready = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  task automatic clear_logs();
    instr_log.delete();
    mem_log.delete();
    tx_log.delete();
  endtask

  function automatic logic [31:0] ilog(input int i);
    return (i < instr_log.size()) ? instr_log[i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] tlog(input int i);
    return (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hxxxxxxxx;
  endfunction

  int          r;
  logic [31:0] len;
  int          nw;
  int          nb;

  initial begin
    do_reset();
    chk("rst_data", data, 32'd0);
    chk("rst_instr", 32'(instr_ready), 32'd0);
    chk("rst_mem", 32'(mem_ready), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_sdata", 32'(sdata), 32'd0);
    chk("rst_loaded", 32'(program_loaded), 32'd0);

    // Two-word program, back-to-back bytes.
    clear_logs();
    send_word(32'd2, 0);
    send_word(32'h44332211, 0);
    send_word(32'h88776655, 0);
    idle(3);
    chk("t1_count", 32'(instr_log.size()), 32'd2);
    chk("t1_w0", ilog(0), 32'h44332211);
    chk("t1_w1", ilog(1), 32'h88776655);
    chk("t1_tx_count", 32'(tx_log.size()), 32'd1);
    chk("t1_ack", tlog(0), 32'hAA);
    chk("t1_loaded", 32'(program_loaded), 32'd1);
    chk("t1_model", 32'(m_mode), 32'(M_RUN));

    // RUN data word.
    clear_logs();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    idle(2);
    chk("t2_mem_count", 32'(mem_log.size()), 32'd1);
    chk("t2_mem_word",
        mem_log.size() > 0 ? mem_log[0] : 32'hxxxxxxxx, 32'h04030201);
    chk("t2_no_instr", 32'(instr_log.size()), 32'd0);
    chk("t2_no_tx", 32'(tx_log.size()), 32'd0);

    // Reset mid-RUN word, then length 1 with tx_busy held in ACK.
    send(8'h5A); send(8'hA5);
    do_reset();
    clear_logs();
    send_word(32'd1, 0);
    tx_busy = 1'b1;
    idle(2);
    chk("t3_loaded_lo", 32'(program_loaded), 32'd0);
    send_word(32'hCAFEF00D, 0);
    idle(20);
    chk("t3_tx_held", 32'(tx_log.size()), 32'd0);
    chk("t3_loaded_wait", 32'(program_loaded), 32'd0);
    chk("t3_word", ilog(0), 32'hCAFEF00D);
    tx_busy = 1'b0;
    idle(3);
    chk("t3_tx_count", 32'(tx_log.size()), 32'd1);
    chk("t3_ack", tlog(0), 32'hAA);
    chk("t3_loaded", 32'(program_loaded), 32'd1);

    // Zero-length program.
    do_reset();
    clear_logs();
    send_word(32'd0, 1);
    idle(3);
    chk("t4_no_instr", 32'(instr_log.size()), 32'd0);
    chk("t4_ack", tlog(0), 32'hAA);
    chk("t4_loaded", 32'(program_loaded), 32'd1);

    // Over-length rejected, then a valid retry.
    do_reset();
    clear_logs();
    send_word(32'h101, 0);
    idle(3);
    chk("t5_nak", tlog(0), 32'hEE);
    chk("t5_loaded_lo", 32'(program_loaded), 32'd0);
    send_word(32'd1, 0);
    send_word(32'hDEADBEEF, 1);
    idle(3);
    chk("t5_word", ilog(0), 32'hDEADBEEF);
    chk("t5_tx_count", 32'(tx_log.size()), 32'd2);
    chk("t5_ack", tlog(1), 32'hAA);
    chk("t5_loaded", 32'(program_loaded), 32'd1);

    // Exactly MAX words.
    do_reset();
    clear_logs();
    send_word(32'(MAX), 0);
    repeat (MAX) send_word($urandom, 0);
    idle(3);
    chk("t6_count", 32'(instr_log.size()), 32'(MAX));
    chk("t6_ack", tlog(0), 32'hAA);
    chk("t6_loaded", 32'(program_loaded), 32'd1);

    // Randomised sessions.
    for (int it = 0; it < 30; it++) begin
      do_reset();
      rand_busy = (it % 2) == 1;
      r = $urandom_range(0, 9);
      if (r == 7) len = 32'(MAX);
      else if (r == 8) len = 32'(MAX) + 1 + $urandom_range(0, 1000);
      else if (r == 9) len = $urandom;
      else len = 32'(r);
      send_word(len, 2);
      nw = (len <= MAX) ? int'(len) : 0;
      for (int k = 0; k < nw; k++) send_word($urandom, 2);
      idle($urandom_range(1, 6));
      nb = $urandom_range(0, 13);
      for (int k = 0; k < nb; k++) begin
        if ($urandom_range(0, 39) == 0) do_reset();
        send(8'($urandom));
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      end
      idle(3);
    end
    rand_busy = 1'b0;
    tx_busy   = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
